// File: rtl/ps2_kbd_pkg.sv
// Shared constants and helpers for the PS/2 keyboard / switch encoder block.
// Contents: PS/2 frame layout constants, scan-code and encoder widths,
//           prio_enc8() returning the index of the highest set bit (0 when input is 0).
package ps2_kbd_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    localparam int unsigned SCAN_W     = 8;
    localparam int unsigned ENC_IN_W   = 8;
    localparam int unsigned ENC_OUT_W  = 3;

    // Later (higher) set bits overwrite earlier ones, so the highest index wins.
    function automatic logic [ENC_OUT_W-1:0] prio_enc8(input logic [ENC_IN_W-1:0] v);
        logic [ENC_OUT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(ENC_IN_W); i++) begin
            if (v[i]) idx = ENC_OUT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ps2_kbd_encoder_if.sv
// Scan-code read bus between the PS/2 receive FIFO and its consumer.
// Signals: rd_en (pop request), data (FIFO head), ready (FIFO not empty),
//          overflow (sticky drop flag), err_cnt (discarded-frame count,
//          present only when PS2_FRAME_CHECK_EN is defined).
// master: the consumer side; slave: the keyboard block.
interface ps2_kbd_encoder_if import ps2_kbd_pkg::*; ;

    logic              rd_en;
    logic [SCAN_W-1:0] data;
    logic              ready;
    logic              overflow;
`ifdef PS2_FRAME_CHECK_EN
    logic [7:0]        err_cnt;
`endif

    modport master (
        output rd_en,
        input  data,
        input  ready,
        input  overflow
`ifdef PS2_FRAME_CHECK_EN
        ,
        input  err_cnt
`endif
    );

    modport slave (
        input  rd_en,
        output data,
        output ready,
        output overflow
`ifdef PS2_FRAME_CHECK_EN
        ,
        output err_cnt
`endif
    );

endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive path: ps2_clk synchroniser, 11-bit frame receiver and scan-code FIFO.
// Ports: clk/rst (async active-high), ps2_clk/ps2_data pins, rd_en pop request,
//        data (FIFO head), ready (not empty), overflow (sticky),
//        err_cnt (saturating discarded-frame count, only with PS2_FRAME_CHECK_EN).
// Build option: PS2_FRAME_CHECK_EN filters frames failing start/stop/parity checks.
module ps2_rx_fifo import ps2_kbd_pkg::*; #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              rd_en,
    output logic [SCAN_W-1:0] data,
    output logic              ready,
    output logic              overflow
`ifdef PS2_FRAME_CHECK_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SR_W  = FRAME_BITS - 1;

    // ps2_clk synchroniser; bit 0 is the newest sample
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_clk};
    end

    assign sample = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];

    // Frame receiver: shift_q holds start, d0..d7, parity (LSB first) once
    // ten bits are in; the stop bit is taken straight from the pin.
    logic [SR_W-1:0]   shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              frame_done;
    logic              frame_ok;
    logic [SCAN_W-1:0] scan;

    assign frame_done = sample && (cnt_q == CNT_W'(FRAME_BITS - 1));
    assign scan       = shift_q[SCAN_W:1];
    assign frame_ok   = (shift_q[0] == START_BIT) && (ps2_data == STOP_BIT)
                        && (^shift_q[SR_W-1:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (sample) begin
            shift_q <= {ps2_data, shift_q[SR_W-1:1]};
            cnt_q   <= frame_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    logic wr_req;

`ifdef PS2_FRAME_CHECK_EN
    assign wr_req = frame_done & frame_ok;

    // Saturating count of frames thrown away by the checks
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          err_cnt <= '0;
        else if (frame_done && !frame_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`else
    assign wr_req = frame_done;

    // Check result is only consumed when frames are filtered
    logic frame_ok_unused;
    assign frame_ok_unused = frame_ok;
`endif

    // Scan-code FIFO with one extra pointer bit to tell full from empty
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [SCAN_W-1:0] mem_q [FIFO_DEPTH];
    logic              empty, full, pop, wr, ovf_set;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
    assign wr      = wr_req & (~full | pop);
    assign ovf_set = wr_req & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (wr) begin
                mem_q[wptr_q[AW-1:0]] <= scan;
                wptr_q                <= wptr_q + PW'(1);
            end
            if (pop)     rptr_q   <= rptr_q + PW'(1);
            if (ovf_set) overflow <= 1'b1;
        end
    end

    assign ready = ~empty;
    assign data  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_encoder.sv
// Board input block: PS/2 keyboard receiver with scan-code FIFO, plus a
// combinational 8-to-3 priority encoder feeding a 3-to-8 decoder for switches.
// Ports: clk/rst (async active-high), ps2_clk/ps2_data pins,
//        bus (ps2_kbd_encoder_if.slave: rd_en, data, ready, overflow[, err_cnt]),
//        enc_in/enc_en -> enc_y/enc_valid, dec_en -> dec_y.
// Build option: PS2_FRAME_CHECK_EN drops bad frames and adds err_cnt to the bus.
module ps2_kbd_encoder import ps2_kbd_pkg::*; #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    ps2_kbd_encoder_if.slave     bus,
    input  logic [ENC_IN_W-1:0]  enc_in,
    input  logic                 enc_en,
    output logic [ENC_OUT_W-1:0] enc_y,
    output logic                 enc_valid,
    input  logic                 dec_en,
    output logic [ENC_IN_W-1:0]  dec_y
);

    // PS/2 receive path
    ps2_rx_fifo #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (bus.rd_en),
        .data     (bus.data),
        .ready    (bus.ready),
        .overflow (bus.overflow)
`ifdef PS2_FRAME_CHECK_EN
        ,
        .err_cnt  (bus.err_cnt)
`endif
    );

    // Switch path: priority encode, then one-hot decode of the winning index
    assign enc_y     = enc_en ? prio_enc8(enc_in) : '0;
    assign enc_valid = enc_en & (|enc_in);
    assign dec_y     = dec_en ? (ENC_IN_W'(1) << enc_y) : '0;

endmodule

// File: tb/tb_ps2_kbd_encoder.sv
// Self-checking bench for ps2_kbd_encoder: encoder/decoder vector table plus
// random vectors, directed PS/2 frame sequences and random frame traffic
// checked against a queue-based FIFO model.
module tb_ps2_kbd_encoder;
    import ps2_kbd_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data;
    logic [7:0] enc_in;
    logic       enc_en, dec_en;
    logic [2:0] enc_y;
    logic       enc_valid;
    logic [7:0] dec_y;

    ps2_kbd_encoder_if bus ();

    ps2_kbd_encoder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .bus       (bus),
        .enc_in    (enc_in),
        .enc_en    (enc_en),
        .enc_y     (enc_y),
        .enc_valid (enc_valid),
        .dec_en    (dec_en),
        .dec_y     (dec_y)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    bit         ovf_m;
    int         err_m;

    typedef struct {
        logic [7:0] in;
        logic       en;
        logic       den;
        logic [2:0] y;
        logic       valid;
        logic [7:0] dy;
    } enc_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: index of highest set bit by repeated halving
    function automatic int ref_idx(input int v);
        int n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad);
        int ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        if (bad) p = ~p;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (30) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (30) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; optional pop on the write cycle and optional write-latency check
    task automatic send_frame(input logic [7:0] d, input bit bad, input bit pop_at_stop,
                              input bit chk_lat);
        logic [10:0] f;
        f = make_frame(d, bad);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = f[10];
        repeat (30) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        if (chk_lat) chk("ready_before_stop_write", 32'(bus.ready), 32'd0);
        if (pop_at_stop) bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (chk_lat) begin
            chk("ready_after_stop_write", 32'(bus.ready), 32'd1);
            chk("data_after_stop_write", 32'(bus.data), 32'(d));
        end
        repeat (27) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic model_push(input logic [7:0] d, input bit bad);
`ifdef PS2_FRAME_CHECK_EN
        if (bad) begin
            if (err_m < 255) err_m++;
            return;
        end
`endif
        if (q.size() < DEPTH) q.push_back(d);
        else                  ovf_m = 1'b1;
    endtask

    task automatic pop_check();
        chk("pop_data", 32'(bus.data), 32'(q[0]));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic check_state(input string nm);
        chk({nm, "_ready"}, 32'(bus.ready), 32'(q.size() != 0));
        chk({nm, "_overflow"}, 32'(bus.overflow), 32'(ovf_m));
`ifdef PS2_FRAME_CHECK_EN
        chk({nm, "_err_cnt"}, 32'(bus.err_cnt), 32'(err_m));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        err_m = 0;
        @(negedge clk);
    endtask

    enc_vec_t vecs[7];

    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        bit          bad, pas;
        int          npop;

        vecs[0] = '{8'b0010_1001, 1'b1, 1'b1, 3'd5, 1'b1, 8'b0010_0000};
        vecs[1] = '{8'b0010_1001, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01};
        vecs[2] = '{8'hFF,        1'b1, 1'b0, 3'd7, 1'b1, 8'h00};
        vecs[3] = '{8'h00,        1'b1, 1'b1, 3'd0, 1'b0, 8'h01};
        vecs[4] = '{8'h80,        1'b1, 1'b1, 3'd7, 1'b1, 8'h80};
        vecs[5] = '{8'h01,        1'b1, 1'b1, 3'd0, 1'b1, 8'h01};
        vecs[6] = '{8'h10,        1'b1, 1'b0, 3'd4, 1'b1, 8'h00};

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.rd_en = 1'b0;
        enc_in = '0; enc_en = 1'b0; dec_en = 1'b0;
        q.delete(); ovf_m = 1'b0; err_m = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_data", 32'(bus.data), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Encoder/decoder table
        foreach (vecs[i]) begin
            enc_in = vecs[i].in; enc_en = vecs[i].en; dec_en = vecs[i].den;
            #1;
            chk($sformatf("enc_y_vec%0d", i), 32'(enc_y), 32'(vecs[i].y));
            chk($sformatf("enc_valid_vec%0d", i), 32'(enc_valid), 32'(vecs[i].valid));
            chk($sformatf("dec_y_vec%0d", i), 32'(dec_y), 32'(vecs[i].dy));
        end

        // Random encoder/decoder vectors against the arithmetic model
        for (int i = 0; i < 64; i++) begin
            int y;
            enc_in = 8'($urandom);
            if (i % 4 == 0) enc_in = 8'($urandom_range(0, 3));
            enc_en = 1'($urandom); dec_en = 1'($urandom);
            #1;
            y = enc_en ? ref_idx(int'(enc_in)) : 0;
            chk("rand_enc_y", 32'(enc_y), 32'(y));
            chk("rand_enc_valid", 32'(enc_valid), 32'(enc_en && enc_in != 0));
            chk("rand_dec_y", 32'(dec_y), dec_en ? 32'(2 ** y) : 32'd0);
        end
        @(negedge clk);

        // Single frame with write latency, then pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        model_push(8'h1C, 1'b0);
        pop_check();
        chk("ready_after_pop", 32'(bus.ready), 32'd0);

        // Nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b0);
            model_push(8'(i), 1'b0);
        end
        chk("overflow_set", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check();
        chk("ready_after_drain", 32'(bus.ready), 32'd0);
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Reset in the middle of a frame
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        model_push(8'h33, 1'b0);
        chk("ready_before_midreset", 32'(bus.ready), 32'd1);
        f = make_frame(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        #2 rst = 1'b1;
        #1;
        chk("midreset_ready", 32'(bus.ready), 32'd0);
        chk("midreset_overflow", 32'(bus.overflow), 32'd0);
        chk("midreset_data", 32'(bus.data), 32'h00);
        q.delete(); ovf_m = 1'b0; err_m = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        model_push(8'h5A, 1'b0);
        chk("after_reset_data", 32'(bus.data), 32'h5A);
        check_state("after_reset");
        pop_check();

        // Write into a full FIFO with a pop on the same cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            model_push(8'(8'h40 + i), 1'b0);
        end
        send_frame(8'h48, 1'b0, 1'b1, 1'b0);
        void'(q.pop_front());
        model_push(8'h48, 1'b0);
        chk("full_pop_write_overflow", 32'(bus.overflow), 32'd0);
        check_state("full_pop_write");
        while (q.size() > 0) pop_check();
        chk("full_pop_write_drained", 32'(bus.ready), 32'd0);

        // Frame with a wrong parity bit
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        model_push(8'h1C, 1'b1);
`ifdef PS2_FRAME_CHECK_EN
        chk("bad_parity_ready", 32'(bus.ready), 32'd0);
        chk("bad_parity_err_cnt", 32'(bus.err_cnt), 32'd1);
`else
        chk("bad_parity_data", 32'(bus.data), 32'h1C);
`endif
        check_state("bad_parity");
        while (q.size() > 0) pop_check();

        // Random frame traffic against the queue model
        do_reset();
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            pas = ($urandom_range(0, 4) == 0);
            send_frame(d, bad, pas, 1'b0);
            if (pas && q.size() > 0) void'(q.pop_front());
            model_push(d, bad);
            check_state("rand_frame");
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) if (q.size() > 0) pop_check();
        end
        while (q.size() > 0) pop_check();
        check_state("rand_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
